// File: rtl/aurora_link_monitor.sv
// -----------------------------------------------------------------------------
// aurora_link_monitor
//
// Supervises an Aurora core after the reset sequencer has released it. It also
// acts as the requester side of the sw_reset handshake. Runs entirely on
// init_clk. Core status inputs are brought in through 2-FF synchronizers. The
// FSM waits for the channel to come up and debounces link loss and hard errors.
// It re-requests a core reset when the link does not come up in time or when an
// established link drops. Statistics counters saturate and can be cleared.
//
// Ports:
//   init_clk        in   clock for all logic
//   rst             in   asynchronous active-high reset
//   enable          in   0 holds the core in reset (FSM parked in ST_DISABLED)
//   sys_reset_out   in   core reset status, asynchronous to init_clk
//   channel_up      in   core channel status, asynchronous
//   lane_up         in   per-lane status, asynchronous, NUM_LANES wide
//   hard_err        in   core hard error level, asynchronous
//   clear_counters  in   single-cycle clear of retry/drop counters
//   sw_reset        out  reset request to the core reset sequencer
//   link_up         out  qualified link status
//   lanes_up        out  synchronized copy of lane_up
//   retry_count     out  saturating count of link-up timeouts
//   link_drop_count out  saturating count of qualified link drops
//   state           out  current FSM state encoding
// -----------------------------------------------------------------------------
module aurora_link_monitor #(
    parameter int  SIMULATION        = 0,
    parameter real INIT_CLK_FREQ_MHZ = 100.0,
    parameter int  LINK_TIMEOUT_MS   = 2000,
    parameter int  NUM_LANES         = 1,
    parameter int  SW_RESET_CYCLES   = 16,
    parameter int  DEBOUNCE_CYCLES   = 16,
    parameter int  CNT_W             = 16
) (
    input  logic                 init_clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 sys_reset_out,
    input  logic                 channel_up,
    input  logic [NUM_LANES-1:0] lane_up,
    input  logic                 hard_err,
    input  logic                 clear_counters,
    output logic                 sw_reset,
    output logic                 link_up,
    output logic [NUM_LANES-1:0] lanes_up,
    output logic [CNT_W-1:0]     retry_count,
    output logic [CNT_W-1:0]     link_drop_count,
    output logic [2:0]           state
);

    // Link-up timeout, measured from sw_reset release. It is shortened in
    // simulation so that a retry can be observed in a few thousand cycles.
    localparam int TIMEOUT_CYCLES = (SIMULATION != 0) ? 2000 :
        $rtoi($ceil(real'(LINK_TIMEOUT_MS) * 1000.0 * INIT_CLK_FREQ_MHZ));

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int DEB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PLS_W = $clog2(SW_RESET_CYCLES + 1);

    // Each counter starts at 0 on the first cycle of its window. The terminal
    // value is therefore one less than the required number of cycles.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PLS_W-1:0] PLS_LAST = PLS_W'(SW_RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        ST_DISABLED     = 3'd0,
        ST_RESET_REQ    = 3'd1,
        ST_WAIT_CORE    = 3'd2,
        ST_WAIT_CHANNEL = 3'd3,
        ST_LINK_UP      = 3'd4
    } state_t;

    // Synchronizer stages
    logic                 sys_reset_meta_r;
    logic                 sys_reset_sync_r;
    logic                 channel_up_meta_r;
    logic                 channel_up_sync_r;
    logic                 hard_err_meta_r;
    logic                 hard_err_sync_r;
    logic [NUM_LANES-1:0] lane_up_meta_r;
    logic [NUM_LANES-1:0] lane_up_sync_r;

    // FSM state, registered outputs and internal counters
    state_t               state_r;
    logic                 sw_reset_r;
    logic                 link_up_r;
    logic [TMO_W-1:0]     tmo_cnt_r;
    logic [DEB_W-1:0]     deb_cnt_r;
    logic [PLS_W-1:0]     pls_cnt_r;
    logic [CNT_W-1:0]     retry_cnt_r;
    logic [CNT_W-1:0]     drop_cnt_r;

    // Decoded conditions
    logic                 in_wait_s;
    logic                 timeout_s;
    logic                 fault_s;
    logic                 deb_full_s;
    logic                 pulse_done_s;
    logic                 retry_inc_s;
    logic                 drop_inc_s;

    // 2-FF synchronizers. The core reset status resets to "in reset".
    always_ff @(posedge init_clk or posedge rst) begin
        if (rst) begin
            sys_reset_meta_r  <= 1'b1;
            sys_reset_sync_r  <= 1'b1;
            channel_up_meta_r <= 1'b0;
            channel_up_sync_r <= 1'b0;
            hard_err_meta_r   <= 1'b0;
            hard_err_sync_r   <= 1'b0;
            lane_up_meta_r    <= {NUM_LANES{1'b0}};
            lane_up_sync_r    <= {NUM_LANES{1'b0}};
        end else begin
            sys_reset_meta_r  <= sys_reset_out;
            sys_reset_sync_r  <= sys_reset_meta_r;
            channel_up_meta_r <= channel_up;
            channel_up_sync_r <= channel_up_meta_r;
            hard_err_meta_r   <= hard_err;
            hard_err_sync_r   <= hard_err_meta_r;
            lane_up_meta_r    <= lane_up;
            lane_up_sync_r    <= lane_up_meta_r;
        end
    end

    // Condition decode shared by the FSM and the statistics counters
    always_comb begin
        in_wait_s    = (state_r == ST_WAIT_CORE) || (state_r == ST_WAIT_CHANNEL);
        timeout_s    = in_wait_s && (tmo_cnt_r == TMO_LAST);
        fault_s      = !channel_up_sync_r || hard_err_sync_r || sys_reset_sync_r;
        deb_full_s   = (deb_cnt_r == DEB_LAST);
        pulse_done_s = (pls_cnt_r == PLS_LAST);
        // A disable in the same cycle suppresses both increments.
        retry_inc_s  = enable && timeout_s;
        drop_inc_s   = enable && (state_r == ST_LINK_UP) && fault_s && deb_full_s;
    end

    // Supervisor FSM. sw_reset and link_up are registered next to the state,
    // so they change on the same edge as the state transition.
    always_ff @(posedge init_clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_DISABLED;
            sw_reset_r <= 1'b1;
            link_up_r  <= 1'b0;
            tmo_cnt_r  <= {TMO_W{1'b0}};
            deb_cnt_r  <= {DEB_W{1'b0}};
            pls_cnt_r  <= {PLS_W{1'b0}};
        end else begin
            // Counters clear unless the branch below keeps them running. This
            // clears them on every state change and outside their states.
            tmo_cnt_r <= {TMO_W{1'b0}};
            deb_cnt_r <= {DEB_W{1'b0}};
            pls_cnt_r <= {PLS_W{1'b0}};
            if (!enable) begin
                state_r    <= ST_DISABLED;
                sw_reset_r <= 1'b1;
                link_up_r  <= 1'b0;
            end else begin
                case (state_r)
                    ST_DISABLED: begin
                        state_r    <= ST_WAIT_CORE;
                        sw_reset_r <= 1'b0;
                        link_up_r  <= 1'b0;
                    end
                    ST_RESET_REQ: begin
                        link_up_r <= 1'b0;
                        if (pulse_done_s) begin
                            state_r    <= ST_WAIT_CORE;
                            sw_reset_r <= 1'b0;
                        end else begin
                            sw_reset_r <= 1'b1;
                            pls_cnt_r  <= pls_cnt_r + PLS_W'(1);
                        end
                    end
                    ST_WAIT_CORE: begin
                        link_up_r <= 1'b0;
                        if (timeout_s) begin
                            state_r    <= ST_RESET_REQ;
                            sw_reset_r <= 1'b1;
                        end else begin
                            sw_reset_r <= 1'b0;
                            // Timeout keeps counting into ST_WAIT_CHANNEL.
                            tmo_cnt_r  <= tmo_cnt_r + TMO_W'(1);
                            if (!sys_reset_sync_r) begin
                                state_r <= ST_WAIT_CHANNEL;
                            end else begin
                                state_r <= ST_WAIT_CORE;
                            end
                        end
                    end
                    ST_WAIT_CHANNEL: begin
                        // Timeout wins over a same-cycle qualification.
                        if (timeout_s) begin
                            state_r    <= ST_RESET_REQ;
                            sw_reset_r <= 1'b1;
                            link_up_r  <= 1'b0;
                        end else if (channel_up_sync_r && deb_full_s) begin
                            state_r    <= ST_LINK_UP;
                            sw_reset_r <= 1'b0;
                            link_up_r  <= 1'b1;
                        end else begin
                            sw_reset_r <= 1'b0;
                            link_up_r  <= 1'b0;
                            tmo_cnt_r  <= tmo_cnt_r + TMO_W'(1);
                            if (channel_up_sync_r) begin
                                deb_cnt_r <= deb_cnt_r + DEB_W'(1);
                            end else begin
                                deb_cnt_r <= {DEB_W{1'b0}};
                            end
                        end
                    end
                    ST_LINK_UP: begin
                        if (fault_s && deb_full_s) begin
                            state_r    <= ST_RESET_REQ;
                            sw_reset_r <= 1'b1;
                            link_up_r  <= 1'b0;
                        end else begin
                            sw_reset_r <= 1'b0;
                            link_up_r  <= 1'b1;
                            if (fault_s) begin
                                deb_cnt_r <= deb_cnt_r + DEB_W'(1);
                            end else begin
                                deb_cnt_r <= {DEB_W{1'b0}};
                            end
                        end
                    end
                    default: begin
                        state_r    <= ST_DISABLED;
                        sw_reset_r <= 1'b1;
                        link_up_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Saturating statistics counters. A clear wins over a same-cycle increment.
    always_ff @(posedge init_clk or posedge rst) begin
        if (rst) begin
            retry_cnt_r <= {CNT_W{1'b0}};
            drop_cnt_r  <= {CNT_W{1'b0}};
        end else if (clear_counters) begin
            retry_cnt_r <= {CNT_W{1'b0}};
            drop_cnt_r  <= {CNT_W{1'b0}};
        end else begin
            if (retry_inc_s && (retry_cnt_r != CNT_MAX)) begin
                retry_cnt_r <= retry_cnt_r + CNT_W'(1);
            end
            if (drop_inc_s && (drop_cnt_r != CNT_MAX)) begin
                drop_cnt_r <= drop_cnt_r + CNT_W'(1);
            end
        end
    end

    assign sw_reset        = sw_reset_r;
    assign link_up         = link_up_r;
    assign lanes_up        = lane_up_sync_r;
    assign retry_count     = retry_cnt_r;
    assign link_drop_count = drop_cnt_r;
    assign state           = state_r;

endmodule

// File: tb/tb_aurora_link_monitor.sv
// -----------------------------------------------------------------------------
// Testbench for aurora_link_monitor.
// Inputs change on the falling clock edge. At each falling edge, a reference
// model predicts the outputs after the next rising edge, and the stimulus
// process queues that prediction. A monitor samples the DUT 3 time units after
// each rising edge and compares it against the oldest queued prediction.
// The model is written with cycle timestamps and the spec's timing rules
// rather than with hardware-style counters.
// -----------------------------------------------------------------------------
module tb_aurora_link_monitor;

    localparam int NL   = 2;
    localparam int CW   = 3;
    localparam int TMO  = 2000;
    localparam int DEB  = 16;
    localparam int SWR  = 16;
    localparam int MAXC = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic          sr_in = 1'b1;
    logic          ch_in = 1'b0;
    logic          he_in = 1'b0;
    logic          clr = 1'b0;
    logic [NL-1:0] ln_in = '0;

    logic          sw_reset;
    logic          link_up;
    logic [NL-1:0] lanes_up;
    logic [CW-1:0] retry_count;
    logic [CW-1:0] link_drop_count;
    logic [2:0]    st;

    aurora_link_monitor #(
        .SIMULATION      (1),
        .NUM_LANES       (NL),
        .SW_RESET_CYCLES (SWR),
        .DEBOUNCE_CYCLES (DEB),
        .CNT_W           (CW)
    ) dut (
        .init_clk        (clk),
        .rst             (rst),
        .enable          (en),
        .sys_reset_out   (sr_in),
        .channel_up      (ch_in),
        .lane_up         (ln_in),
        .hard_err        (he_in),
        .clear_counters  (clr),
        .sw_reset        (sw_reset),
        .link_up         (link_up),
        .lanes_up        (lanes_up),
        .retry_count     (retry_count),
        .link_drop_count (link_drop_count),
        .state           (st)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]    st;
        logic          swr;
        logic          lu;
        logic [NL-1:0] ln;
        logic [CW-1:0] rc;
        logic [CW-1:0] dc;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic void chk(string name, int act, int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endfunction

    // ---------------- reference model ----------------
    // States: 0 disabled, 1 reset request, 2 wait core, 3 wait channel, 4 link up.
    // cyc is the index of the current clock cycle. entry_c, wait_start and
    // streak_start are the cycle indices at which the current state, the
    // current wait window and the current qualifying run began.
    int            m_st, m_rc, m_dc, cyc, entry_c, wait_start, streak_start;
    bit            s1_sr, s2_sr, s1_ch, s2_ch, s1_he, s2_he;
    bit [NL-1:0]   s1_ln, s2_ln;

    function automatic void model_reset();
        m_st = 0; m_rc = 0; m_dc = 0;
        s1_sr = 1'b1; s2_sr = 1'b1;
        s1_ch = 1'b0; s2_ch = 1'b0;
        s1_he = 1'b0; s2_he = 1'b0;
        s1_ln = '0;   s2_ln = '0;
        entry_c = cyc; wait_start = cyc; streak_start = cyc;
    endfunction

    function automatic bit timeout_due();
        return !rst && en && (m_st == 2 || m_st == 3) && (cyc - wait_start + 1 == TMO);
    endfunction

    function automatic void model_step();
        int   nxt;
        bit   to, dr, fault;
        exp_t e;
        if (rst) begin
            model_reset();
        end else begin
            nxt   = m_st;
            to    = 1'b0;
            dr    = 1'b0;
            fault = !s2_ch || s2_he || s2_sr;
            if (!en) nxt = 0;
            else begin
                case (m_st)
                    0: nxt = 2;
                    1: if (cyc - entry_c + 1 == SWR) nxt = 2;
                    2, 3: begin
                        if (cyc - wait_start + 1 == TMO) begin nxt = 1; to = 1'b1; end
                        else if (m_st == 2 && !s2_sr) nxt = 3;
                        else if (m_st == 3 && s2_ch && (cyc - streak_start + 1 == DEB)) nxt = 4;
                    end
                    4: if (fault && (cyc - streak_start + 1 == DEB)) begin nxt = 1; dr = 1'b1; end
                    default: nxt = 0;
                endcase
            end
            if (nxt == m_st) begin
                if (m_st == 3 && !s2_ch) streak_start = cyc + 1;
                if (m_st == 4 && !fault) streak_start = cyc + 1;
            end else begin
                entry_c      = cyc + 1;
                streak_start = cyc + 1;
                if (nxt == 2) wait_start = cyc + 1;
            end
            if (clr) begin
                m_rc = 0; m_dc = 0;
            end else begin
                if (to && m_rc < MAXC) m_rc++;
                if (dr && m_dc < MAXC) m_dc++;
            end
            m_st  = nxt;
            s2_sr = s1_sr; s1_sr = sr_in;
            s2_ch = s1_ch; s1_ch = ch_in;
            s2_he = s1_he; s1_he = he_in;
            s2_ln = s1_ln; s1_ln = ln_in;
        end
        cyc++;
        e.st  = 3'(m_st);
        e.swr = (m_st == 0 || m_st == 1);
        e.lu  = (m_st == 4);
        e.ln  = s2_ln;
        e.rc  = CW'(m_rc);
        e.dc  = CW'(m_dc);
        q.push_back(e);
    endfunction

    // Predict the upcoming edge with the inputs as they are now, then wait a cycle.
    task automatic tick();
        model_step();
        @(negedge clk);
    endtask

    task automatic run_until_state(int target, int limit, string name);
        int n = 0;
        while (m_st != target && n < limit) begin
            tick();
            n++;
        end
        chk(name, int'(st), target);
    endtask

    // ---------------- monitor ----------------
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #3;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("sb_state",      int'(st),              int'(e.st));
                chk("sb_sw_reset",   int'(sw_reset),        int'(e.swr));
                chk("sb_link_up",    int'(link_up),         int'(e.lu));
                chk("sb_lanes_up",   int'(lanes_up),        int'(e.ln));
                chk("sb_retry",      int'(retry_count),     int'(e.rc));
                chk("sb_link_drop",  int'(link_drop_count), int'(e.dc));
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin : stimulus
        int lat, swr_cnt, nto, saved_rc;
        bit hit;
        cyc = 0;
        model_reset();
        @(negedge clk);

        // Reset, then hold disabled.
        repeat (5) tick();
        rst = 1'b0;
        repeat (100) tick();
        chk("disabled_sw_reset", int'(sw_reset), 1);

        // Bring-up: sys_reset_out falls at cycle 10, channel_up rises at 50.
        en  = 1'b1;
        lat = -1;
        for (int i = 0; i < 120; i++) begin
            if (i == 10) sr_in = 1'b0;
            if (i == 30) ln_in = '1;
            if (i == 50) ch_in = 1'b1;
            tick();
            if (lat < 0 && link_up) lat = i;
        end
        chk("bringup_latency_le_69", (lat >= 0 && lat <= 69) ? 1 : 0, 1);
        chk("bringup_retry", int'(retry_count), 0);

        // Short drop (< debounce) is ignored.
        ch_in = 1'b0;
        repeat (10) tick();
        ch_in = 1'b1;
        repeat (30) tick();
        chk("short_drop_state", int'(st), 4);
        chk("short_drop_count", int'(link_drop_count), 0);

        // Long drop: one 16-cycle sw_reset pulse and one counted drop.
        swr_cnt = 0;
        ch_in   = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (i == 20) ch_in = 1'b1;
            tick();
            if (sw_reset) swr_cnt++;
        end
        chk("long_drop_pulse_len", swr_cnt, SWR);
        chk("long_drop_count", int'(link_drop_count), 1);
        repeat (20) tick();

        // Channel never comes up: two timeouts.
        ch_in = 1'b0;
        nto   = 0;
        while (m_rc < 2 && nto < 6000) begin
            tick();
            nto++;
        end
        chk("two_timeouts_retry", int'(retry_count), 2);

        // Disable in the wait-channel state: back to disabled, retry unchanged.
        run_until_state(3, 100, "reach_wait_channel");
        saved_rc = int'(retry_count);
        en = 1'b0;
        tick();
        chk("disable_state", int'(st), 0);
        chk("disable_retry", int'(retry_count), saved_rc);
        en = 1'b1;

        // Clear in the same cycle as a timeout increment.
        hit = 1'b0;
        for (int i = 0; i < 3000 && !hit; i++) begin
            if (timeout_due()) begin
                clr = 1'b1;
                hit = 1'b1;
            end
            tick();
            clr = 1'b0;
        end
        chk("clear_timeout_found", int'(hit), 1);
        chk("clear_vs_timeout_retry", int'(retry_count), 0);

        // Saturation of the retry counter.
        nto = 0;
        for (int i = 0; i < 25000 && nto < MAXC + 2; i++) begin
            if (timeout_due()) nto++;
            tick();
        end
        chk("retry_saturated", int'(retry_count), MAXC);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            if (sr_in) begin
                if ($urandom_range(0, 99) < 10) sr_in = 1'b0;
            end else begin
                if ($urandom_range(0, 199) == 0) sr_in = 1'b1;
            end
            if ($urandom_range(0, 99) < 3) ch_in = ~ch_in;
            if ($urandom_range(0, 199) == 0) he_in = 1'b1;
            else if ($urandom_range(0, 19) == 0) he_in = 1'b0;
            if ($urandom_range(0, 19) == 0) ln_in = NL'($urandom);
            clr = ($urandom_range(0, 299) == 0);
            en  = ($urandom_range(0, 499) != 0);
            tick();
        end

        // Asynchronous reset in the middle of link-up.
        en = 1'b1; clr = 1'b0; he_in = 1'b0; sr_in = 1'b0; ch_in = 1'b1;
        run_until_state(4, 3000, "reach_link_up");
        repeat (5) tick();
        chk("pre_rst_link_up", int'(link_up), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_link_up",  int'(link_up),         0);
        chk("async_rst_sw_reset", int'(sw_reset),        1);
        chk("async_rst_state",    int'(st),              0);
        chk("async_rst_retry",    int'(retry_count),     0);
        chk("async_rst_drop",     int'(link_drop_count), 0);
        chk("async_rst_lanes",    int'(lanes_up),        0);
        tick();
        repeat (3) tick();
        rst = 1'b0;
        repeat (50) tick();

        @(posedge clk);
        #5;
        chk("scoreboard_drained", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
